// File: rtl/rtc_sched_pkg.sv
// Shared mode encoding and default addresses/slots for the RTC access scheduler.
package rtc_sched_pkg;

  typedef enum logic [2:0] {
    M_INIT   = 3'd0,
    M_READ   = 3'd1,
    M_SRESET = 3'd2,
    M_WRITE  = 3'd3,
    M_TPROG  = 3'd4,
    M_TRUN   = 3'd5
  } mode_e;

  localparam logic [6:0] SAFE_SLOT_DEF = 7'h4A;
  localparam logic [7:0] TMR_BASE_DEF  = 8'h41;
  localparam logic [7:0] CLR_ADDR_DEF  = 8'h01;
  localparam logic [7:0] RST_END_DEF   = 8'h02;

endpackage

// File: rtl/rtc_alarm_match.sv
// Per-field timer compare, sticky match flags and ring generation.
// RTC_RING_HOLD_EN: ring latches until i_ring_ack; otherwise ring tracks the full match.
module rtc_alarm_match
  import rtc_sched_pkg::*;
#(
  parameter int                N_FIELDS = 3,
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] TMR_BASE = ADDR_W'(TMR_BASE_DEF),
  parameter logic [ADDR_W-1:0] CLR_ADDR = ADDR_W'(CLR_ADDR_DEF)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_rd_valid,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic [DATA_W-1:0]            i_rd_data,
  input  logic [N_FIELDS*DATA_W-1:0]   i_tmr_set,
  input  logic                         i_ring_ack,
  output logic [N_FIELDS-1:0]          o_match,
  output logic                         o_ring
);

  logic [N_FIELDS-1:0] r_match;
  logic [N_FIELDS-1:0] w_hit;
  logic                w_clr;
  logic                w_ring_set;
  logic                r_ring;

  for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_fld
    assign w_hit[gi] = i_rd_valid && (i_addr == TMR_BASE + ADDR_W'(gi)) &&
                       (i_rd_data == i_tmr_set[gi*DATA_W +: DATA_W]);
  end

  // An unprogrammed timer (all fields zero) must never alarm, so it clears like a CLR read.
  assign w_clr      = (i_rd_valid && i_addr == CLR_ADDR) || (i_tmr_set == '0);
  assign w_ring_set = (&r_match) && (|i_tmr_set);

  always_ff @(posedge i_clk) begin
    if (i_reset)    r_match <= '0;
    else if (w_clr) r_match <= '0;
    else            r_match <= r_match | w_hit;
  end

`ifdef RTC_RING_HOLD_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)          r_ring <= 1'b0;
    else if (w_ring_set)  r_ring <= 1'b1;
    else if (i_ring_ack)  r_ring <= 1'b0;
  end
`else
  logic w_unused_ack;
  assign w_unused_ack = i_ring_ack;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_ring <= 1'b0;
    else         r_ring <= w_ring_set;
  end
`endif

  assign o_match = r_match;
  assign o_ring  = r_ring;

endmodule

// File: rtl/rtc_access_scheduler.sv
// RTC bus-ownership scheduler: mode FSM, bus mux and timer alarm.
// RTC_RING_HOLD_EN selects latched ring behaviour in rtc_alarm_match.
module rtc_access_scheduler
  import rtc_sched_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                SLOT_W      = 7,
  parameter logic [SLOT_W-1:0] SAFE_SLOT   = SLOT_W'(SAFE_SLOT_DEF),
  parameter int                INIT_CYCLES = 1034,
  parameter int                N_FIELDS    = 3,
  parameter logic [ADDR_W-1:0] TMR_BASE    = ADDR_W'(TMR_BASE_DEF),
  parameter logic [ADDR_W-1:0] CLR_ADDR    = ADDR_W'(CLR_ADDR_DEF),
  parameter logic [ADDR_W-1:0] RST_END     = ADDR_W'(RST_END_DEF)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_req_reset,
  input  logic                        i_req_write,
  input  logic                        i_req_tprog,
  input  logic                        i_req_trun,
  input  logic [SLOT_W-1:0]           i_slot_cnt,
  input  logic [ADDR_W-1:0]           i_init_addr,
  input  logic [DATA_W-1:0]           i_init_data,
  input  logic [ADDR_W-1:0]           i_rd_addr,
  input  logic [ADDR_W-1:0]           i_wr_addr,
  input  logic [DATA_W-1:0]           i_wr_data,
  input  logic [DATA_W-1:0]           i_rd_data,
  input  logic [N_FIELDS*DATA_W-1:0]  i_tmr_set,
  input  logic                        i_ring_ack,
  output logic [2:0]                  o_mode,
  output logic [ADDR_W-1:0]           o_bus_addr,
  output logic [DATA_W-1:0]           o_bus_data,
  output logic                        o_bus_wr,
  output logic                        o_init_busy,
  output logic [N_FIELDS-1:0]         o_match,
  output logic                        o_ring
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);

  mode_e            r_mode, w_mode_nxt, w_arb;
  logic [CNT_W-1:0] r_init_cnt;
  logic             r_req_reset, r_req_write, r_req_tprog, r_req_trun;
  logic             w_safe;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mode      <= M_INIT;
      r_init_cnt  <= '0;
      r_req_reset <= 1'b0;
      r_req_write <= 1'b0;
      r_req_tprog <= 1'b0;
      r_req_trun  <= 1'b0;
    end else begin
      r_mode      <= w_mode_nxt;
      r_init_cnt  <= (r_mode == M_INIT) ? r_init_cnt + 1'b1 : '0;
      r_req_reset <= i_req_reset;
      r_req_write <= i_req_write;
      r_req_tprog <= i_req_tprog;
      r_req_trun  <= i_req_trun;
    end
  end

  assign w_safe = (i_slot_cnt == SAFE_SLOT);

  always_comb begin
    w_arb = M_READ;
    if      (r_req_reset) w_arb = M_SRESET;
    else if (r_req_write) w_arb = M_WRITE;
    else if (r_req_tprog) w_arb = M_TPROG;
    else if (r_req_trun)  w_arb = M_TRUN;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      M_INIT:   if (r_init_cnt == CNT_W'(INIT_CYCLES - 1)) w_mode_nxt = M_READ;
      // Soft reset ends on the init machine's progress, not on the slot.
      M_SRESET: if (!r_req_reset && i_init_addr == RST_END) w_mode_nxt = M_READ;
      default:  if (w_safe) w_mode_nxt = w_arb;
    endcase
  end

  always_comb begin
    o_bus_addr = i_rd_addr;
    o_bus_data = '0;
    o_bus_wr   = 1'b0;
    case (r_mode)
      M_INIT, M_SRESET: begin
        o_bus_addr = i_init_addr;
        o_bus_data = i_init_data;
        o_bus_wr   = 1'b1;
      end
      M_WRITE, M_TPROG, M_TRUN: begin
        o_bus_addr = i_wr_addr;
        o_bus_data = i_wr_data;
        o_bus_wr   = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_mode      = r_mode;
  assign o_init_busy = (r_mode == M_INIT) || (r_mode == M_SRESET);

  rtc_alarm_match #(
    .N_FIELDS (N_FIELDS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TMR_BASE (TMR_BASE),
    .CLR_ADDR (CLR_ADDR)
  ) u_alarm (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rd_valid (r_mode == M_READ),
    .i_addr     (o_bus_addr),
    .i_rd_data  (i_rd_data),
    .i_tmr_set  (i_tmr_set),
    .i_ring_ack (i_ring_ack),
    .o_match    (o_match),
    .o_ring     (o_ring)
  );

endmodule
